// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial-receive side signals of the UART receiver.
//   b_tick    : 16x oversampling tick, single clk wide (into receiver)
//   rx        : raw serial line, idle high, asynchronous (into receiver)
//   rx_data   : last correctly received byte (from receiver)
//   rx_done   : one-cycle pulse when rx_data updates (from receiver)
//   frame_err : one-cycle pulse on a bad stop bit (from receiver)
//   rx_busy   : high whenever the receiver is not idle (from receiver)
// The slave modport is the receiver; the master modport is its environment.
// ---------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 b_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        output b_tick,
        output rx,
        input  rx_data,
        input  rx_done,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  b_tick,
        input  rx,
        output rx_data,
        output rx_done,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 (DATA_BITS configurable) UART receiver driven by a 16x oversampling
// tick. The serial line is double-flopped, the start bit is re-checked at
// its centre, data bits are sampled LSB-first at each bit centre and the
// stop bit is verified before the byte is presented.
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active low
//   bus : uart_rx_if slave (b_tick, rx in; rx_data, rx_done, frame_err,
//         rx_busy out)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t               state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_r, data_n;
    logic                 done_r, done_n;
    logic                 err_r, err_n;

    // Synchroniser stage: rx -> sync_p0 -> sync_p1 (= rx_s), reset to idle level
    logic sync_p0, sync_p1;
    logic rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= bus.rx;
            sync_p1 <= sync_p0;
        end
    end

    assign rx_s = sync_p1;

    // Frame state register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            data_r   <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            data_r   <= data_n;
            done_r   <= done_n;
            err_r    <= err_n;
        end
    end

    // Next-state / output decode
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        data_n  = data_r;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                // Edge detection runs every clk; b_tick is irrelevant here.
                if (!rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end

            START: begin
                if (bus.b_tick) begin
                    if (tick_cnt == TICK_MID) begin
                        // A line that is high again at mid start bit was a glitch.
                        if (!rx_s) begin
                            state_n = DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (bus.b_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        // Right shift: first received bit ends up in the LSB.
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        tick_n  = '0;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (bus.b_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n = '0;
                        // Returning to IDLE at the stop-bit centre leaves half a
                        // bit of margin for a back-to-back start edge.
                        if (rx_s) begin
                            data_n  = shreg;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = BRK;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end

            BRK: begin
                // Hold off new frames until the line has returned high.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.rx_data   = data_r;
    assign bus.rx_done   = done_r;
    assign bus.frame_err = err_r;
    assign bus.rx_busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Bench for uart_rx: a free-running tick source, a serial frame driver and a
// monitor that logs every rx_done / frame_err pulse. Expected bytes, pulse
// counts and frame timings come from the frame format itself (start bit
// centre + DATA_BITS bit periods + one stop period).
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 5;
    // Ticks from the start edge to the stop-bit sample that raises rx_done.
    localparam int FRAME_LAT = OS / 2 + OS * DB + OS;
    localparam int FRAME_LEN = OS * (DB + 2);

    logic clk;
    logic rst;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    int tick_idx = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int busy_at_done = 0;
    logic [DB-1:0] data_q[$];
    int            done_tick_q[$];
    int            last_fall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick source: one-clk pulse every TICK_DIV clocks, changed on negedge.
    initial begin
        int div;
        div = 0;
        bus.b_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (div == TICK_DIV - 1) begin
                div = 0;
                bus.b_tick = 1'b1;
                tick_idx++;
            end else begin
                div++;
                bus.b_tick = 1'b0;
            end
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (bus.rx_done === 1'b1) begin
            done_cnt++;
            data_q.push_back(bus.rx_data);
            done_tick_q.push_back(tick_idx);
            if (bus.rx_busy !== 1'b0) busy_at_done++;
        end
        if (bus.frame_err === 1'b1) err_cnt++;
        if (bus.rx_done === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp);
        total++;
        assert ((obs >= exp - 1) && (obs <= exp + 1)) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d+-1", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (bus.b_tick !== 1'b1);
        end
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk);
        bus.rx = v;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop);
        @(negedge clk);
        bus.rx = 1'b0;
        last_fall = tick_idx;
        wait_ticks(OS);
        for (int i = 0; i < DB; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    function automatic logic [31:0] pop_data();
        if (data_q.size() > 0) return 32'(data_q.pop_front());
        return 'x;
    endfunction

    function automatic int pop_tick();
        if (done_tick_q.size() > 0) return done_tick_q.pop_front();
        return -1000;
    endfunction

    initial begin
        int d0, e0, f1, f2, t1, t2;
        logic [DB-1:0] rb;
        logic [DB-1:0] exp_q[$];

        // Reset state
        rst    = 1'b0;
        bus.rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", 32'(bus.rx_data), 32'h0);
        check("reset_rx_done", 32'(bus.rx_done), 32'h0);
        check("reset_frame_err", 32'(bus.frame_err), 32'h0);
        check("reset_rx_busy", 32'(bus.rx_busy), 32'h0);
        rst = 1'b1;
        wait_ticks(4);

        // Single frame 0x55
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h55, 1'b1);
        f1 = last_fall;
        wait_ticks(4);
        check("t1_done_count", 32'(done_cnt - d0), 32'd1);
        check("t1_data", pop_data(), 32'h55);
        check_near("t1_latency", pop_tick() - f1, FRAME_LAT);
        check("t1_no_err", 32'(err_cnt - e0), 32'd0);
        check("t1_busy_at_done", 32'(busy_at_done), 32'd0);

        // Back-to-back 0xA3, 0x0F
        d0 = done_cnt;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_ticks(4);
        check("t2_done_count", 32'(done_cnt - d0), 32'd2);
        check("t2_data0", pop_data(), 32'hA3);
        check("t2_data1", pop_data(), 32'h0F);
        t1 = pop_tick();
        t2 = pop_tick();
        check_near("t2_spacing", t2 - t1, FRAME_LEN);

        // Start glitch: 3 ticks low
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        bus.rx = 1'b0;
        wait_ticks(3);
        @(negedge clk);
        bus.rx = 1'b1;
        wait_ticks(1);
        #1;
        check("t3_busy_in_start", 32'(bus.rx_busy), 32'd1);
        wait_ticks(8);
        #1;
        check("t3_idle_after", 32'(bus.rx_busy), 32'd0);
        check("t3_no_done", 32'(done_cnt - d0), 32'd0);
        check("t3_no_err", 32'(err_cnt - e0), 32'd0);
        check("t3_data_kept", 32'(bus.rx_data), 32'h0F);

        // Bad stop bit on 0x3C
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        wait_ticks(8);
        #1;
        check("t4_err_count", 32'(err_cnt - e0), 32'd1);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_busy_low_line", 32'(bus.rx_busy), 32'd1);
        check("t4_data_kept", 32'(bus.rx_data), 32'h0F);
        @(negedge clk);
        bus.rx = 1'b1;
        wait_ticks(2);
        #1;
        check("t4_idle_after_high", 32'(bus.rx_busy), 32'd0);

        // Break: 20 bit times low
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        bus.rx = 1'b0;
        wait_ticks(20 * OS);
        #1;
        check("t5_err_count", 32'(err_cnt - e0), 32'd1);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        check("t5_busy_in_break", 32'(bus.rx_busy), 32'd1);
        @(negedge clk);
        bus.rx = 1'b1;
        wait_ticks(OS);
        send_frame(8'h81, 1'b1);
        wait_ticks(4);
        check("t5_done_after", 32'(done_cnt - d0), 32'd1);
        check("t5_data", pop_data(), 32'h81);
        check("t5_err_stable", 32'(err_cnt - e0), 32'd1);

        // Reset during data bit 4
        rb = DB'($urandom);
        @(negedge clk);
        bus.rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) send_bit(rb[i]);
        @(negedge clk);
        bus.rx = rb[4];
        wait_ticks(OS / 2);
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        rst    = 1'b0;
        bus.rx = 1'b1;
        #1;
        check("t6_rst_data", 32'(bus.rx_data), 32'h0);
        check("t6_rst_done", 32'(bus.rx_done), 32'h0);
        check("t6_rst_err", 32'(bus.frame_err), 32'h0);
        check("t6_rst_busy", 32'(bus.rx_busy), 32'h0);
        wait_ticks(4);
        @(negedge clk);
        rst = 1'b1;
        wait_ticks(2 * OS);
        check("t6_no_pulse_done", 32'(done_cnt - d0), 32'd0);
        check("t6_no_pulse_err", 32'(err_cnt - e0), 32'd0);
        send_frame(8'hC6, 1'b1);
        wait_ticks(4);
        check("t6_done_count", 32'(done_cnt - d0), 32'd1);
        check("t6_data", pop_data(), 32'hC6);

        // Random back-to-back frames
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 6; i++) begin
            rb = DB'($urandom);
            exp_q.push_back(rb);
            send_frame(rb, 1'b1);
        end
        wait_ticks(4);
        check("t7_done_count", 32'(done_cnt - d0), 32'd6);
        check("t7_no_err", 32'(err_cnt - e0), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t7_data%0d", i), pop_data(), 32'(exp_q[i]));
        end

        check("never_done_and_err", 32'(both_cnt), 32'd0);
        check("busy_low_on_done", 32'(busy_at_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
